// File: rtl/bcd_ctrl_pkg.sv
// Shared types and helpers for the BCD count controller.
// Holds the controller state encoding, BCD digit constants and the
// limit-validation function used when a terminal value is captured.
package bcd_ctrl_pkg;

    localparam int          BCD_W      = 4;
    localparam logic [3:0]  BCD_MAX    = 4'd9;
    localparam int          MAX_DIGITS = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } ctrl_state_e;

    // Returns 1 when any of the low 'digits' nibbles of 'value' is not a decimal digit.
    function automatic logic bcd_has_bad_nibble(
        input logic [MAX_DIGITS*BCD_W-1:0] value,
        input int                          digits
    );
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < MAX_DIGITS; i++) begin
            if ((i < digits) && (value[i*BCD_W +: BCD_W] > BCD_MAX)) begin
                bad = 1'b1;
            end else begin
                bad = bad;
            end
        end
        return bad;
    endfunction

endpackage

// File: rtl/bcd_count_ctrl_if.sv
// Command / chain bundle between the host side and the BCD count controller.
// The master side issues command pulses and presents the chain read-back;
// the slave side is the controller itself.
interface bcd_count_ctrl_if
    import bcd_ctrl_pkg::*;
#(
    parameter int DIGITS = 4
);
    logic                    cmd_start;
    logic                    cmd_stop;
    logic                    cmd_clear;
    logic [BCD_W*DIGITS-1:0] limit_bcd;
    logic [BCD_W*DIGITS-1:0] count_bcd;
    logic                    cnt_tick;
    logic                    cnt_clear;
    logic                    running;
    logic                    done;
    logic                    limit_err;

    modport master (
        output cmd_start, cmd_stop, cmd_clear, limit_bcd, count_bcd,
        input  cnt_tick, cnt_clear, running, done, limit_err
    );

    modport slave (
        input  cmd_start, cmd_stop, cmd_clear, limit_bcd, count_bcd,
        output cnt_tick, cnt_clear, running, done, limit_err
    );
endinterface

// File: rtl/bcd_tick_prescaler.sv
// Free-running divider that produces the count-tick timing for the chain.
// Counts 0..PRESCALE-1 while enabled, holds while disabled, and returns to
// zero on restart. 'wrap' is high in the cycle the counter rolls over.
module bcd_tick_prescaler #(
    parameter int PRESCALE = 12_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic restart,
    output logic wrap
);
    localparam int            CW   = $clog2(PRESCALE);
    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] cnt_r;

    // Phase counter: restart wins, otherwise advance and roll over while enabled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= '0;
        end else if (restart) begin
            cnt_r <= '0;
        end else if (en) begin
            if (cnt_r == LAST) begin
                cnt_r <= '0;
            end else begin
                cnt_r <= cnt_r + CW'(1);
            end
        end
    end

    assign wrap = en && (cnt_r == LAST);

endmodule

// File: rtl/bcd_count_ctrl.sv
// Run/stop/clear controller for a cascaded BCD digit-counter chain.
// Issues the chain's count tick from a prescaler, drives its synchronous clear,
// and halts when the chain read-back equals the captured BCD limit.
// Optional feature macro: BCD_COUNT_CTRL_AUTO_RESTART_EN -- on reaching the
// limit, clear the chain, pulse done and keep running instead of stopping.
module bcd_count_ctrl
    import bcd_ctrl_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int PRESCALE = 12_000_000
) (
    input  logic             sys_clk,
    input  logic             sys_reset,
    bcd_count_ctrl_if.slave  bus
);
    localparam int VW = BCD_W * DIGITS;

    ctrl_state_e state_r, state_nxt;
    logic [VW-1:0] limit_q_r, limit_nxt;
    logic          limit_err_r, err_nxt;
    logic          cnt_tick_r, tick_nxt;
    logic          cnt_clear_r, clear_nxt;
    logic          running_r, running_nxt;
    logic          done_r, done_nxt;
    logic          done_pulse_s;
    logic          presc_en_s;
    logic          presc_restart_s;
    logic          wrap_s;
    logic          at_limit_s;
    logic          limit_bad_s;
    logic [MAX_DIGITS*BCD_W-1:0] limit_ext_s;

    bcd_tick_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
        .clk     (sys_clk),
        .rst     (sys_reset),
        .en      (presc_en_s),
        .restart (presc_restart_s),
        .wrap    (wrap_s)
    );

    assign limit_ext_s = (MAX_DIGITS*BCD_W)'(bus.limit_bcd);
    assign limit_bad_s = bcd_has_bad_nibble(limit_ext_s, DIGITS);
    assign at_limit_s  = (bus.count_bcd == limit_q_r);

    // Next-state and next-output decode; clear beats stop, stop beats start.
    always_comb begin
        state_nxt       = state_r;
        limit_nxt       = limit_q_r;
        err_nxt         = limit_err_r;
        tick_nxt        = 1'b0;
        clear_nxt       = 1'b0;
        done_pulse_s    = 1'b0;
        presc_en_s      = 1'b0;
        presc_restart_s = 1'b0;
        if (bus.cmd_clear) begin
            state_nxt       = IDLE;
            clear_nxt       = 1'b1;
            err_nxt         = 1'b0;
            presc_restart_s = 1'b1;
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.cmd_start && !bus.cmd_stop) begin
                        limit_nxt       = bus.limit_bcd;
                        err_nxt         = limit_bad_s;
                        presc_restart_s = 1'b1;
                        state_nxt       = limit_bad_s ? IDLE : RUN;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
                RUN: begin
                    if (bus.cmd_stop) begin
                        // Prescaler holds so a later resume keeps the tick phase.
                        state_nxt = PAUSE;
                    end else begin
                        presc_en_s = 1'b1;
                        if (wrap_s && at_limit_s) begin
`ifdef BCD_COUNT_CTRL_AUTO_RESTART_EN
                            clear_nxt       = 1'b1;
                            done_pulse_s    = 1'b1;
                            presc_restart_s = 1'b1;
                            state_nxt       = RUN;
`else
                            state_nxt = DONE;
`endif
                        end else if (wrap_s) begin
                            tick_nxt = 1'b1;
                        end else begin
                            tick_nxt = 1'b0;
                        end
                    end
                end
                PAUSE: begin
                    if (bus.cmd_stop) begin
                        state_nxt = PAUSE;
                    end else if (bus.cmd_start) begin
                        state_nxt = RUN;
                    end else begin
                        state_nxt = PAUSE;
                    end
                end
                DONE: begin
                    state_nxt = DONE;
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
        running_nxt = (state_nxt == RUN);
        done_nxt    = (state_nxt == DONE) || done_pulse_s;
    end

    // Controller state register.
    always_ff @(posedge sys_clk or posedge sys_reset) begin
        if (sys_reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt;
        end
    end

    // Registered outputs and captured limit; clear is held high by reset so the chain zeroes.
    always_ff @(posedge sys_clk or posedge sys_reset) begin
        if (sys_reset) begin
            limit_q_r   <= '0;
            limit_err_r <= 1'b0;
            cnt_tick_r  <= 1'b0;
            cnt_clear_r <= 1'b1;
            running_r   <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            limit_q_r   <= limit_nxt;
            limit_err_r <= err_nxt;
            cnt_tick_r  <= tick_nxt;
            cnt_clear_r <= clear_nxt;
            running_r   <= running_nxt;
            done_r      <= done_nxt;
        end
    end

    assign bus.cnt_tick  = cnt_tick_r;
    assign bus.cnt_clear = cnt_clear_r;
    assign bus.running   = running_r;
    assign bus.done      = done_r;
    assign bus.limit_err = limit_err_r;

endmodule

// File: tb/tb_bcd_count_ctrl.sv
// Bench for bcd_count_ctrl with DIGITS=2, PRESCALE=4.
// A two-digit cascaded BCD chain is modelled here; expectations come from
// decimal arithmetic on the limit (tick count, latency, run-cycle budget).
module tb_bcd_count_ctrl;
    import bcd_ctrl_pkg::*;

    localparam int DIGITS   = 2;
    localparam int PRESCALE = 4;

    logic sys_clk   = 1'b0;
    logic sys_reset = 1'b0;
    logic [7:0] chain = 8'h77;

    int tests      = 0;
    int fails      = 0;
    int tick_count = 0;
    int done_edges = 0;
    int run_edges  = 0;

    bcd_count_ctrl_if #(.DIGITS(DIGITS)) bus ();

    bcd_count_ctrl #(.DIGITS(DIGITS), .PRESCALE(PRESCALE)) dut (
        .sys_clk   (sys_clk),
        .sys_reset (sys_reset),
        .bus       (bus)
    );

    always #5 sys_clk = ~sys_clk;

    assign bus.count_bcd = chain;

    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        logic [3:0] lo;
        logic [3:0] hi;
        lo = v[3:0];
        hi = v[7:4];
        if (lo == 4'd9) begin
            lo = 4'd0;
            hi = (hi == 4'd9) ? 4'd0 : hi + 4'd1;
        end else begin
            lo = lo + 4'd1;
        end
        return {hi, lo};
    endfunction

    function automatic int bcd_val(input logic [7:0] v);
        return int'(v[7:4]) * 10 + int'(v[3:0]);
    endfunction

    // Digit chain: synchronous clear, otherwise count up on tick.
    always @(posedge sys_clk) begin
        if (bus.cnt_clear) chain <= 8'h00;
        else if (bus.cnt_tick) chain <= bcd_inc(chain);
    end

    // Event monitors.
    always @(posedge sys_clk) begin
        if (bus.cnt_tick) tick_count <= tick_count + 1;
        if (bus.done)     done_edges <= done_edges + 1;
        if (bus.running)  run_edges  <= run_edges + 1;
    end

    task automatic drive_cmd(input logic s, input logic p, input logic c, input logic [7:0] lim);
        bus.cmd_start = s;
        bus.cmd_stop  = p;
        bus.cmd_clear = c;
        bus.limit_bcd = lim;
        @(negedge sys_clk);
        bus.cmd_start = 1'b0;
        bus.cmd_stop  = 1'b0;
        bus.cmd_clear = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int waited, output bit seen);
        waited = 0;
        seen   = 1'b0;
        while (waited < budget && !seen) begin
            if (bus.done) seen = 1'b1;
            else begin
                @(negedge sys_clk);
                waited++;
            end
        end
    endtask

    task automatic test_reset();
        bus.cmd_start = 1'b0;
        bus.cmd_stop  = 1'b0;
        bus.cmd_clear = 1'b0;
        bus.limit_bcd = 8'h00;
        #1 sys_reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge sys_clk);
            tests++;
            if (bus.cnt_clear !== 1'b1) begin
                fails++;
                $display("FAIL reset_clear: got %b expected 1", bus.cnt_clear);
            end
            tests++;
            if ({bus.cnt_tick, bus.running, bus.done, bus.limit_err} !== 4'b0000) begin
                fails++;
                $display("FAIL reset_outs: got %b expected 0000",
                         {bus.cnt_tick, bus.running, bus.done, bus.limit_err});
            end
        end
        sys_reset = 1'b0;
        #1;
        tests++;
        if (bus.cnt_clear !== 1'b1) begin
            fails++;
            $display("FAIL release_clear: got %b expected 1", bus.cnt_clear);
        end
        @(negedge sys_clk);
        tests++;
        if (bus.cnt_clear !== 1'b0 || chain !== 8'h00) begin
            fails++;
            $display("FAIL post_reset: got clear=%b chain=%h expected clear=0 chain=00",
                     bus.cnt_clear, chain);
        end
    endtask

    task automatic test_run_to_limit(input logic [7:0] lim);
        int  n, t0, k;
        bit  seen;
        n  = bcd_val(lim);
        t0 = tick_count;
        drive_cmd(1'b1, 1'b0, 1'b0, lim);
        tests++;
        if (bus.limit_err !== 1'b0 || bus.running !== 1'b1) begin
            fails++;
            $display("FAIL start_%h: got err=%b run=%b expected err=0 run=1", lim, bus.limit_err, bus.running);
        end
        wait_done(PRESCALE * (n + 1) + 8, k, seen);
        tests++;
        if (!seen || k != PRESCALE * (n + 1)) begin
            fails++;
            $display("FAIL done_latency_%h: got %0d (seen=%b) expected %0d", lim, k, seen, PRESCALE * (n + 1));
        end
        tests++;
        if (tick_count - t0 != n || chain !== lim) begin
            fails++;
            $display("FAIL ticks_%h: got %0d chain=%h expected %0d chain=%h", lim, tick_count - t0, chain, n, lim);
        end
        repeat (2 * PRESCALE) @(negedge sys_clk);
        tests++;
        if (tick_count - t0 != n || bus.done !== 1'b1 || bus.running !== 1'b0) begin
            fails++;
            $display("FAIL hold_%h: got ticks=%0d done=%b expected ticks=%0d done=1", lim, tick_count - t0, bus.done, n);
        end
        drive_cmd(1'b0, 1'b0, 1'b1, lim);
        tests++;
        if (bus.done !== 1'b0 || bus.cnt_clear !== 1'b1) begin
            fails++;
            $display("FAIL clear_after_%h: got done=%b clr=%b expected done=0 clr=1", lim, bus.done, bus.cnt_clear);
        end
        @(negedge sys_clk);
        tests++;
        if (bus.cnt_clear !== 1'b0 || chain !== 8'h00) begin
            fails++;
            $display("FAIL clear_pulse_%h: got clr=%b chain=%h expected clr=0 chain=00", lim, bus.cnt_clear, chain);
        end
    endtask

    task automatic test_random_limits();
        logic [7:0] lim;
        for (int i = 0; i < 4; i++) begin
            lim = {4'($urandom_range(0, 2)), 4'($urandom_range(0, 9))};
            test_run_to_limit(lim);
        end
    endtask

    task automatic test_pause_resume();
        int t0, t1, r0, k;
        bit seen;
        r0 = run_edges;
        t0 = tick_count;
        drive_cmd(1'b1, 1'b0, 1'b0, 8'h05);
        k = 0;
        while (tick_count - t0 < 2 && k < 40) begin
            @(negedge sys_clk);
            k++;
        end
        repeat ($urandom_range(0, 3)) @(negedge sys_clk);
        drive_cmd(1'b0, 1'b1, 1'b0, 8'h00);
        t1 = tick_count;
        repeat (20) @(negedge sys_clk);
        tests++;
        if (tick_count != t1 || bus.running !== 1'b0 || bus.done !== 1'b0) begin
            fails++;
            $display("FAIL paused: got ticks+%0d run=%b done=%b expected +0 0 0", tick_count - t1, bus.running, bus.done);
        end
        drive_cmd(1'b1, 1'b0, 1'b0, 8'h00);
        wait_done(60, k, seen);
        tests++;
        if (!seen || tick_count - t0 != 5 || chain !== 8'h05) begin
            fails++;
            $display("FAIL resume_end: got seen=%b ticks=%0d chain=%h expected 1 5 05", seen, tick_count - t0, chain);
        end
        tests++;
        if (run_edges - r0 != PRESCALE * 6 + 1) begin
            fails++;
            $display("FAIL resume_phase: got %0d run cycles expected %0d", run_edges - r0, PRESCALE * 6 + 1);
        end
        drive_cmd(1'b0, 1'b0, 1'b1, 8'h00);
        @(negedge sys_clk);
    endtask

    task automatic test_priority();
        int t0;
        drive_cmd(1'b1, 1'b0, 1'b0, 8'h09);
        repeat (5) @(negedge sys_clk);
        drive_cmd(1'b1, 1'b1, 1'b0, 8'h09);
        t0 = tick_count;
        repeat (8) @(negedge sys_clk);
        tests++;
        if (bus.running !== 1'b0 || bus.done !== 1'b0 || tick_count != t0) begin
            fails++;
            $display("FAIL stop_start: got run=%b done=%b ticks+%0d expected 0 0 +0", bus.running, bus.done, tick_count - t0);
        end
        drive_cmd(1'b1, 1'b1, 1'b1, 8'h00);
        tests++;
        if (bus.cnt_clear !== 1'b1 || bus.running !== 1'b0) begin
            fails++;
            $display("FAIL all_cmds: got clr=%b run=%b expected clr=1 run=0", bus.cnt_clear, bus.running);
        end
        @(negedge sys_clk);
        tests++;
        if (bus.cnt_clear !== 1'b0 || chain !== 8'h00) begin
            fails++;
            $display("FAIL all_cmds_pulse: got clr=%b chain=%h expected 0 00", bus.cnt_clear, chain);
        end
        // Fresh capture of limit 0 proves the controller returned to idle.
        test_run_to_limit(8'h00);
    endtask

    task automatic test_limit_err();
        int t0;
        logic [7:0] bad;
        t0 = tick_count;
        drive_cmd(1'b1, 1'b0, 1'b0, 8'h1A);
        tests++;
        if (bus.limit_err !== 1'b1 || bus.running !== 1'b0) begin
            fails++;
            $display("FAIL err_1A: got err=%b run=%b expected 1 0", bus.limit_err, bus.running);
        end
        repeat (3 * PRESCALE) @(negedge sys_clk);
        tests++;
        if (tick_count != t0 || bus.running !== 1'b0 || bus.limit_err !== 1'b1) begin
            fails++;
            $display("FAIL err_idle: got ticks+%0d run=%b err=%b expected +0 0 1", tick_count - t0, bus.running, bus.limit_err);
        end
        drive_cmd(1'b0, 1'b0, 1'b1, 8'h00);
        tests++;
        if (bus.limit_err !== 1'b0) begin
            fails++;
            $display("FAIL err_clear: got %b expected 0", bus.limit_err);
        end
        bad = {4'($urandom_range(10, 15)), 4'($urandom_range(0, 9))};
        drive_cmd(1'b1, 1'b0, 1'b0, bad);
        tests++;
        if (bus.limit_err !== 1'b1) begin
            fails++;
            $display("FAIL err_%h: got %b expected 1", bad, bus.limit_err);
        end
        // A following valid start clears the error and runs normally.
        test_run_to_limit(8'h02);
    endtask

    task automatic test_done_sticky();
        int k, t0;
        bit seen;
        drive_cmd(1'b1, 1'b0, 1'b0, 8'h01);
        wait_done(20, k, seen);
        t0 = tick_count;
        drive_cmd(1'b1, 1'b0, 1'b0, 8'h05);
        drive_cmd(1'b0, 1'b1, 1'b0, 8'h05);
        repeat (8) @(negedge sys_clk);
        tests++;
        if (!seen || bus.done !== 1'b1 || bus.running !== 1'b0 || tick_count != t0 || chain !== 8'h01) begin
            fails++;
            $display("FAIL done_sticky: got seen=%b done=%b run=%b ticks+%0d chain=%h expected 1 1 0 +0 01",
                     seen, bus.done, bus.running, tick_count - t0, chain);
        end
        drive_cmd(1'b0, 1'b0, 1'b1, 8'h00);
        tests++;
        if (bus.done !== 1'b0 || bus.cnt_clear !== 1'b1) begin
            fails++;
            $display("FAIL done_clear: got done=%b clr=%b expected 0 1", bus.done, bus.cnt_clear);
        end
        @(negedge sys_clk);
    endtask

    task automatic test_auto_restart();
        int d0, t0, period, span, max_seen;
        period   = PRESCALE * (3 + 1);
        span     = 50;
        max_seen = 0;
        d0 = done_edges;
        t0 = tick_count;
        drive_cmd(1'b1, 1'b0, 1'b0, 8'h03);
        for (int i = 0; i < span; i++) begin
            @(negedge sys_clk);
            if (bcd_val(chain) > max_seen) max_seen = bcd_val(chain);
            tests++;
            if (bus.running !== 1'b1) begin
                fails++;
                $display("FAIL auto_running: got %b expected 1 at cycle %0d", bus.running, i);
            end
        end
        tests++;
        if (done_edges - d0 != (span - 1) / period || tick_count - t0 != 3 * ((span - 1) / period)) begin
            fails++;
            $display("FAIL auto_counts: got done=%0d ticks=%0d expected %0d %0d",
                     done_edges - d0, tick_count - t0, (span - 1) / period, 3 * ((span - 1) / period));
        end
        tests++;
        if (max_seen != 3) begin
            fails++;
            $display("FAIL auto_max: got %0d expected 3", max_seen);
        end
    endtask

    initial begin
        test_reset();
`ifdef BCD_COUNT_CTRL_AUTO_RESTART_EN
        test_auto_restart();
`else
        test_run_to_limit(8'h12);
        test_run_to_limit(8'h00);
        test_random_limits();
        test_pause_resume();
        test_priority();
        test_limit_err();
        test_done_sticky();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
